// File: rtl/pet2001_vcapture.sv
// pet2001_vcapture
// Locks onto the PET 2001 448x262 raster from its sync/blank strobes and
// repacks the serial 1-bpp active area into bytes. One framebuffer write is
// issued per completed byte at address line*40 + byte. Geometry violations
// drop lock and force a re-sync on the next VSync rising edge.
module pet2001_vcapture #(
  parameter int H_ACTIVE       = 320,
  parameter int V_ACTIVE       = 200,
  parameter int BYTES_PER_LINE = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_7mp,
  input  logic        pix,
  input  logic        HSync,
  input  logic        VSync,
  input  logic        HBlank,
  input  logic        VBlank,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        err
);

  localparam logic [8:0] H_ACT_C = 9'(H_ACTIVE);
  localparam logic [7:0] V_ACT_C = 8'(V_ACTIVE);
  localparam logic [5:0] BPL_C   = 6'(BYTES_PER_LINE);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  // Previous sampled strobe values for edge detection
  logic        vsync_d_r;
  logic        hblank_d_r;
  logic        vblank_d_r;

  // Raster counters and byte assembly
  logic [8:0]  px_r;
  logic [7:0]  ln_r;
  logic [5:0]  bx_r;
  logic [6:0]  sh_r;

  logic [8:0]  px_nxt_s;
  logic [7:0]  ln_nxt_s;
  logic [5:0]  bx_nxt_s;
  logic [6:0]  sh_nxt_s;

  // Decoded raster events (all qualified by ce_7mp)
  logic        vs_rise_s;
  logic        hb_rise_s;
  logic        hb_fall_s;
  logic        vb_rise_s;
  logic        vb_fall_s;
  logic        pix_act_s;
  logic        line_chk_s;
  logic        line_bad_s;
  logic        line_ok_s;
  logic [7:0]  ln_eff_s;
  logic        frame_ok_s;
  logic [8:0]  px_base_s;
  logic [5:0]  bx_base_s;
  logic        byte_end_s;
  logic [12:0] addr_s;

  // FSM-derived controls
  logic        cap_clr_s;
  logic        cap_act_s;
  logic        wr_set_s;
  logic        err_set_s;
  logic        done_set_s;

  // HSync carries no information the capture needs; lines are framed by HBlank.
  logic        unused_hsync_s;
  assign unused_hsync_s = HSync;

  // Decode strobe edges, line/frame geometry checks and per-pixel bases
  always_comb begin
    vs_rise_s  = ce_7mp & VSync & ~vsync_d_r;
    hb_rise_s  = ce_7mp & HBlank & ~hblank_d_r;
    hb_fall_s  = ce_7mp & ~HBlank & hblank_d_r;
    vb_rise_s  = ce_7mp & VBlank & ~vblank_d_r;
    vb_fall_s  = ce_7mp & ~VBlank & vblank_d_r;
    pix_act_s  = ce_7mp & ~HBlank & ~VBlank;
    // A line ends when HBlank rises while the previous sample was still
    // outside vertical blank, so a line closing on the same sample that
    // VBlank rises is checked before the frame check.
    line_chk_s = hb_rise_s & (~VBlank | ~vblank_d_r);
    line_bad_s = line_chk_s & ((px_r != H_ACT_C) | (bx_r != BPL_C));
    line_ok_s  = line_chk_s & ~line_bad_s;
    if (line_ok_s) begin
      ln_eff_s = ln_r + 8'd1;
    end else begin
      ln_eff_s = ln_r;
    end
    frame_ok_s = (ln_eff_s == V_ACT_C);
    if (hb_fall_s) begin
      px_base_s = 9'd0;
      bx_base_s = 6'd0;
    end else begin
      px_base_s = px_r;
      bx_base_s = bx_r;
    end
    byte_end_s = (px_base_s[2:0] == 3'd7);
    addr_s     = {ln_r, 5'b00000} + {2'b00, ln_r, 3'b000} + {7'b0000000, bx_base_s};
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_SEARCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SEARCH: begin
        if (vs_rise_s) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_ARM: begin
        if (vb_fall_s) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_CAPTURE: begin
        if (line_bad_s) begin
          state_nxt_s = ST_SEARCH;
        end else if (vb_rise_s) begin
          if (frame_ok_s) begin
            state_nxt_s = ST_ARM;
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end else if (vs_rise_s) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      default: begin
        state_nxt_s = ST_SEARCH;
      end
    endcase
  end

  // FSM outputs: counter clear on arm, capture enable, write and event strobes
  always_comb begin
    cap_clr_s  = 1'b0;
    cap_act_s  = 1'b0;
    wr_set_s   = 1'b0;
    err_set_s  = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        cap_clr_s = 1'b0;
      end
      ST_ARM: begin
        cap_clr_s = vb_fall_s;
      end
      ST_CAPTURE: begin
        cap_act_s = 1'b1;
        wr_set_s  = pix_act_s & byte_end_s;
        if (line_bad_s) begin
          err_set_s = 1'b1;
        end else if (vb_rise_s) begin
          if (frame_ok_s) begin
            done_set_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else if (vs_rise_s) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
      end
      default: begin
        cap_clr_s = 1'b0;
      end
    endcase
  end

  // Next values of the raster counters and byte shifter
  always_comb begin
    px_nxt_s = px_r;
    bx_nxt_s = bx_r;
    ln_nxt_s = ln_r;
    sh_nxt_s = sh_r;
    if (cap_clr_s) begin
      px_nxt_s = 9'd0;
      bx_nxt_s = 6'd0;
      ln_nxt_s = 8'd0;
    end else if (cap_act_s) begin
      if (pix_act_s) begin
        px_nxt_s = px_base_s + 9'd1;
        sh_nxt_s = {sh_r[5:0], pix};
        if (byte_end_s) begin
          bx_nxt_s = bx_base_s + 6'd1;
        end else begin
          bx_nxt_s = bx_base_s;
        end
      end else begin
        px_nxt_s = px_base_s;
        bx_nxt_s = bx_base_s;
      end
      ln_nxt_s = ln_eff_s;
    end else begin
      px_nxt_s = px_r;
      bx_nxt_s = bx_r;
    end
  end

  // Counters and edge history advance only on pixel-enable samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d_r  <= 1'b0;
      hblank_d_r <= 1'b0;
      vblank_d_r <= 1'b0;
      px_r       <= 9'd0;
      bx_r       <= 6'd0;
      ln_r       <= 8'd0;
      sh_r       <= 7'd0;
    end else if (ce_7mp) begin
      vsync_d_r  <= VSync;
      hblank_d_r <= HBlank;
      vblank_d_r <= VBlank;
      px_r       <= px_nxt_s;
      bx_r       <= bx_nxt_s;
      ln_r       <= ln_nxt_s;
      sh_r       <= sh_nxt_s;
    end
  end

  // Registered framebuffer write, event pulses and lock flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= 13'd0;
      wr_data    <= 8'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      wr_en      <= wr_set_s;
      frame_done <= done_set_s;
      err        <= err_set_s;
      if (wr_set_s) begin
        wr_addr <= addr_s;
        wr_data <= {sh_r, pix};
      end
      if (done_set_s) begin
        locked <= 1'b1;
      end else if (err_set_s) begin
        locked <= 1'b0;
      end
    end
  end

endmodule
